// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: FUNCT3 op codes,
// FSM states and operand-signedness helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    function automatic logic op1_signed(input logic [2:0] funct3);
        return (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
               (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] funct3);
        return (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, quot_i[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    // A borrow out of the subtraction means the divisor did not fit: restore.
    assign rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_o  = {quot_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle RV32M/RV64M multiply/divide unit, one bit per cycle on operand
// magnitudes with a final sign fixup. Define MDU_FAST_MUL_EN for a one-edge multiplier.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic            flush_i,
    input  logic            result_ack_i,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              s1_neg, s2_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_fix;
    logic [XLEN-1:0]   div_rem, div_quot, quot_fix, rem_fix, calc_result;

    assign s1_neg = op1_signed(funct3_i) & operand1_i[XLEN-1];
    assign s2_neg = op2_signed(funct3_i) & operand2_i[XLEN-1];
    assign mag1   = s1_neg ? (~operand1_i + 1'b1) : operand1_i;
    assign mag2   = s2_neg ? (~operand2_i + 1'b1) : operand2_i;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}.
    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quot_i    (acc_q[XLEN-1:0]),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .quot_o    (div_quot)
    );
    assign div_next = {div_rem, div_quot};

    assign acc_step = is_div(funct3_q) ? div_next : mul_next;
    assign prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
    assign quot_fix = neg_q ? (~acc_step[XLEN-1:0] + 1'b1) : acc_step[XLEN-1:0];
    assign rem_fix  = rem_neg_q ? (~acc_step[2*XLEN-1:XLEN] + 1'b1) : acc_step[2*XLEN-1:XLEN];

    always_comb begin
        case (funct3_q)
            MDU_MUL:           calc_result = prod_fix[XLEN-1:0];
            MDU_DIV, MDU_DIVU: calc_result = quot_fix;
            MDU_REM, MDU_REMU: calc_result = rem_fix;
            default:           calc_result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    logic [XLEN-1:0]   fast_result;
    assign fast_mag    = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign fast_prod   = (s1_neg ^ s2_neg) ? (~fast_mag + 1'b1) : fast_mag;
    assign fast_result = (funct3_i == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        funct3_d  = funct3_i;
                        cnt_d     = '0;
                        neg_d     = s1_neg ^ s2_neg;
                        rem_neg_d = s1_neg;
                        if (is_div(funct3_i) && (operand2_i == '0)) begin
                            // x/0: quotient all ones, remainder is the dividend.
                            result_d = funct3_i[1] ? operand1_i : '1;
                            state_d  = ST_DONE;
`ifdef MDU_FAST_MUL_EN
                        end else if (!is_div(funct3_i)) begin
                            result_d = fast_result;
                            state_d  = ST_DONE;
`endif
                        end else begin
                            opnd_d  = is_div(funct3_i) ? mag2 : mag1;
                            acc_d   = {{XLEN{1'b0}}, (is_div(funct3_i) ? mag1 : mag2)};
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = calc_result;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ack_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign result_valid_o = (state_q == ST_DONE);
    assign result_o       = result_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle (XLEN=32): directed RISC-V cases,
// flush/reset/hold behaviour and randomized ops against a 64-bit arithmetic model.
module tb_mdu_multicycle;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1, op2;
  logic            flush, ack;
  logic            busy, valid;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_result;

  mdu_multicycle #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .funct3_i       (funct3),
    .operand1_i     (op1),
    .operand2_i     (op2),
    .flush_i        (flush),
    .result_ack_i   (ack),
    .busy_o         (busy),
    .result_valid_o (valid),
    .result_o       (result),
    .dbg_state_o    (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit arithmetic.
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return '1;
        p = sa / sb;
        return p[31:0];
      end
      3'b101: return (b == 0) ? '1 : a / b;
      3'b110: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accept edge until RESULT_VALID; single-edge paths finish on the accept edge.
  function automatic int exp_latency(input logic [2:0] f, input logic [XLEN-1:0] b);
    if (f[2] && b == 0) return 0;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 0;
`endif
    return XLEN;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag);
    int lat;
    int want;
    logic [XLEN-1:0] e;
    exp_q.push_back(ref_model(f, a, b));
    want = exp_latency(f, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom;
    if (want > 0) chk({tag, " busy"}, busy, 1'b1);
    lat = 0;
    while (valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, want);
    e = exp_q[0];
    chk(tag, result, e);
    last_result = e;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1; start = 1'b1; funct3 = 3'b000; op1 = 32'd3; op2 = 32'd4;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    chk("ack busy", busy, 1'b0);
    chk("ack valid", valid, 1'b0);
  endtask

  initial begin
    logic [XLEN-1:0] held;
    logic [XLEN-1:0] e;
    logic [2:0] rf;
    logic [XLEN-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; funct3 = '0; op1 = '0; op2 = '0; flush = 1'b0; ack = 1'b0;
    last_result = '0;
    #22;
    chk("reset busy", busy, 1'b0);
    chk("reset valid", valid, 1'b0);
    chk("reset result", result, 32'h0);
    chk("reset state", dbg_state, 2'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul 7*-3"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh min*min"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b100, 32'hFFFF_FFEC, 32'd3, "div -20/3"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b110, 32'hFFFF_FFEC, 32'd3, "rem -20/3"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b101, 32'd20, 32'd3, "divu 20/3"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b111, 32'd20, 32'd3, "remu 20/3"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b101, 32'd5, 32'd0, "divu 5/0"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b110, 32'd5, 32'd0, "rem 5/0"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1"); void'(exp_q.pop_front()); do_ack();
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem min/-1"); void'(exp_q.pop_front()); do_ack();

    // Result held across 5 unacknowledged cycles; START in DONE and in the ACK cycle is ignored.
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "hold mul");
    void'(exp_q.pop_front());
    held = last_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b1; funct3 = 3'b101; op1 = 32'd9; op2 = 32'd0;
      @(posedge clk); #1;
      n_checks++;
      if (valid !== 1'b1) begin
        n_errors++;
        $error("FAIL hold valid: observed=%0h expected=1", valid);
      end
      n_checks++;
      if (result !== held) begin
        n_errors++;
        $error("FAIL hold result: observed=%0h expected=%0h", result, held);
      end
    end
    start = 1'b0;
    do_ack();
    @(posedge clk); #1;
    chk("post ack idle", busy, 1'b0);

    // Flush while dividing, at iteration 10.
    @(negedge clk); start = 1'b1; funct3 = 3'b101; op1 = 32'd1000; op2 = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1; start = 1'b1; funct3 = 3'b000; op1 = 32'd2; op2 = 32'd2;
    @(posedge clk); #1; flush = 1'b0; start = 1'b0;
    chk("flush busy", busy, 1'b0);
    chk("flush valid", valid, 1'b0);
    chk("flush result kept", result, last_result);
    repeat (3) @(posedge clk); #1;
    chk("flush stays idle", busy, 1'b0);
    chk("flush no valid", valid, 1'b0);
    run_op(3'b100, 32'hFFFF_FC18, 32'd7, "after flush div"); void'(exp_q.pop_front()); do_ack();

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk); start = 1'b1; funct3 = 3'b001; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst valid", valid, 1'b0);
    chk("async rst result", result, 32'h0);
    chk("async rst state", dbg_state, 2'd0);
    last_result = '0;
    @(negedge clk); rst_n = 1'b1;
    run_op(3'b011, 32'hDEAD_BEEF, 32'h0000_1000, "after reset mulhu"); void'(exp_q.pop_front()); do_ack();

    for (int i = 0; i < 30; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      run_op(rf, ra, rb, "random op");
      e = exp_q.pop_front();
      n_checks++;
      if (result !== e) begin
        n_errors++;
        $error("FAIL random scoreboard f=%0d a=%0h b=%0h: observed=%0h expected=%0h", rf, ra, rb, result, e);
      end
      do_ack();
      n_checks++;
      if ({busy, valid} !== 2'b00) begin
        n_errors++;
        $error("FAIL random ack idle: busy=%0b valid=%0b", busy, valid);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
